// File: rtl/pgm_pkg.sv
// Shared definitions for the PGM packet store: widths, FAST flag codes, replay FSM encoding.
package pgm_pkg;

    localparam int unsigned AW       = 7;    // RAM address width (128 words)
    localparam int unsigned RW       = 144;  // RAM word width
    localparam int unsigned DW       = 134;  // FAST data width
    localparam int unsigned CW       = 32;   // packet counter width
    localparam int unsigned GW       = 16;   // gap counter width
    localparam int unsigned RD_LAT   = 1;    // RAM read latency
    // FINISH dwell: read latency plus the output register stage
    localparam int unsigned FIN_WAIT = RD_LAT + 1;

    localparam logic [1:0] FLAG_HEAD = 2'b01;
    localparam logic [1:0] FLAG_BODY = 2'b11;
    localparam logic [1:0] FLAG_TAIL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ALF = 3'd1,
        ST_READ     = 3'd2,
        ST_GAP      = 3'd3,
        ST_FINISH   = 3'd4
    } state_e;

    // FAST flag for a word from its index within the packet
    function automatic logic [1:0] word_flag(input logic [AW-1:0] idx,
                                             input logic [AW-1:0] last_idx);
        logic [1:0] flag;
        flag = FLAG_BODY;
        if (idx == '0) begin
            flag = FLAG_HEAD;
        end else if (idx == last_idx) begin
            flag = FLAG_TAIL;
        end
        return flag;
    endfunction

endpackage

// File: rtl/pgm_pkt_replay.sv
// Replays one stored packet from the PGM RAM toward GOE in FAST format,
// a programmable number of times with an inter-packet gap.
// The WAIT_ALF decision cycle counts as one of the inter-packet idle cycles,
// so the idle time between packets is max(gap,1) when in_alf is low.
module pgm_pkt_replay
    import pgm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [6:0]    pkt_len,
    input  logic [31:0]   send_cnt,
    input  logic [15:0]   gap,
    output logic          ram_rd,
    output logic [6:0]    ram_raddr,
    input  logic [143:0]  ram_rdata,
    input  logic          in_alf,
    output logic [133:0]  out_data,
    output logic          out_data_wr,
    output logic          out_valid_wr,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic          len_err,
    output logic [31:0]   sent_pkts
);

    state_e         state_q, state_d;
    logic [AW-1:0]  len_q, len_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]     fin_cnt_q, fin_cnt_d;
    logic [CW-1:0]  issued_q, issued_d;
    logic           stop_q, stop_d;
    logic           rd_q, rd_d;
    logic [AW-1:0]  raddr_q, raddr_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           len_err_q, len_err_d;

    logic           p1_vld_q, p1_vld_d;
    logic [1:0]     p1_flag_q, p1_flag_d;
    logic [DW-1:0]  od_q, od_d;
    logic           owr_q, owr_d;
    logic           ovwr_q, ovwr_d;
    logic [CW-1:0]  sent_q, sent_d;

    logic           accept_c;
    logic           last_word_c;
    logic           quota_met_c;
    logic [AW-1:0]  last_idx_c;
    logic           unused_rdata_hi;

    assign last_idx_c      = len_q - AW'(1);
    assign last_word_c     = (raddr_q == last_idx_c);
    assign quota_met_c     = (cnt_q != '0) && ((issued_q + CW'(1)) == cnt_q);
    // stored flag bits and spare RAM bits are replaced / dropped
    assign unused_rdata_hi = ^ram_rdata[RW-1:DW-2];

    // Session FSM: next state, read address generation, session bookkeeping
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        fin_cnt_d = fin_cnt_q;
        issued_d  = issued_q;
        stop_d    = stop_q;
        rd_d      = 1'b0;
        raddr_d   = raddr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        len_err_d = len_err_q;
        accept_c  = 1'b0;

        if (state_q != ST_IDLE && stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (pkt_len >= AW'(2)) begin
                        accept_c  = 1'b1;
                        state_d   = ST_WAIT_ALF;
                        busy_d    = 1'b1;
                        len_d     = pkt_len;
                        cnt_d     = send_cnt;
                        gap_d     = gap;
                        issued_d  = '0;
                        stop_d    = stop;
                        len_err_d = 1'b0;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_ALF: begin
                // a stop recorded together with start still lets the first packet out
                if (stop || (stop_q && issued_q != '0)) begin
                    state_d   = ST_FINISH;
                    fin_cnt_d = '0;
                end else if (!in_alf) begin
                    state_d = ST_READ;
                    rd_d    = 1'b1;
                    raddr_d = '0;
                end
            end
            ST_READ: begin
                if (last_word_c) begin
                    issued_d = issued_q + CW'(1);
                    if (stop || stop_q || quota_met_c) begin
                        state_d   = ST_FINISH;
                        fin_cnt_d = '0;
                    end else if (gap_q > GW'(1)) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GW'(1);
                    end else begin
                        state_d = ST_WAIT_ALF;
                    end
                end else begin
                    rd_d    = 1'b1;
                    raddr_d = raddr_q + AW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == (gap_q - GW'(1))) begin
                    state_d = ST_WAIT_ALF;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_FINISH: begin
                if (fin_cnt_q == 2'(FIN_WAIT)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    stop_d  = 1'b0;
                end else begin
                    fin_cnt_d = fin_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output pipe: tag the read with its flag, merge with RAM data one cycle later
    always_comb begin
        p1_vld_d  = rd_q;
        p1_flag_d = word_flag(raddr_q, last_idx_c);
        od_d      = '0;
        owr_d     = p1_vld_q;
        ovwr_d    = 1'b0;
        sent_d    = sent_q;
        if (p1_vld_q) begin
            od_d   = {p1_flag_q, ram_rdata[DW-3:0]};
            ovwr_d = (p1_flag_q == FLAG_TAIL);
        end
        if (accept_c) begin
            sent_d = '0;
        end else if (p1_vld_q && p1_flag_q == FLAG_TAIL) begin
            sent_d = sent_q + CW'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            fin_cnt_q <= '0;
            issued_q  <= '0;
            stop_q    <= 1'b0;
            rd_q      <= 1'b0;
            raddr_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            p1_vld_q  <= 1'b0;
            p1_flag_q <= '0;
            od_q      <= '0;
            owr_q     <= 1'b0;
            ovwr_q    <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            fin_cnt_q <= fin_cnt_d;
            issued_q  <= issued_d;
            stop_q    <= stop_d;
            rd_q      <= rd_d;
            raddr_q   <= raddr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            p1_vld_q  <= p1_vld_d;
            p1_flag_q <= p1_flag_d;
            od_q      <= od_d;
            owr_q     <= owr_d;
            ovwr_q    <= ovwr_d;
            sent_q    <= sent_d;
        end
    end

    assign ram_rd       = rd_q;
    assign ram_raddr    = raddr_q;
    assign out_data     = od_q;
    assign out_data_wr  = owr_q;
    assign out_valid_wr = ovwr_q;
    assign out_valid    = ovwr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign len_err      = len_err_q;
    assign sent_pkts    = sent_q;

endmodule
